rv32_long_op_scoreboard: RTL

RV32_LONG_OP_SCOREBOARD -- requirements
Module: rv32_long_op_scoreboard

---
 rtl/rv32_long_op_scoreboard.sv | 110 +++++++++++
 1 files changed

// File: rtl/rv32_long_op_scoreboard.sv
// rv32_long_op_scoreboard
//   Busy-bit scoreboard for long-latency (div / iterative mul) register writes.
//   Decode queries up to NUM_READ source operands per cycle and is stalled on a
//   read-after-write hazard against any register still awaiting writeback, or
//   when MAX_OUTSTANDING long ops are already in flight.
//   A same-cycle writeback is forwarded, so it never causes a stall.
//   Optional macro RV32_SB_WAW_CHECK_EN adds a write-after-write stall.
//
// Handshake: an issue is accepted when issue_valid & issue_long & !stall &
//   issue_rd != 0. The acceptance is visible in busy_mask on the next rising
//   edge. wb_valid is a one-cycle, always-accepted event. flush and rst
//   discard all pending state; flush also forces stall low.
module rv32_long_op_scoreboard #(
  parameter int NUM_READ        = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_READ-1:0]      use_rs,
  input  logic [NUM_READ-1:0][4:0] rs_id,
  input  logic                     issue_valid,
  input  logic                     issue_long,
  input  logic [4:0]               issue_rd,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic                     flush,
  output logic                     stall,
  output logic [31:0]              busy_mask,
  output logic [4:0]               outstanding,
  output logic                     full
);

  localparam logic [4:0] MAX_CNT = 5'(MAX_OUTSTANDING);

  logic [31:0] busy_q;
  logic [31:0] wb_onehot;
  logic [31:0] eff_busy;
  logic [31:0] busy_next;
  logic [4:0]  cnt_q;
  logic [4:0]  cnt_next;
  logic        wb_clears;
  logic        raw_stall;
  logic        full_stall;
  logic        waw_stall;
  logic        accept;

  assign busy_mask   = busy_q;
  assign outstanding = cnt_q;
  assign full        = (cnt_q == MAX_CNT);

  // Effective busy view: a register being written back this cycle is forwarded.
  always_comb begin
    wb_onehot = '0;
    if (wb_valid) wb_onehot = 32'd1 << wb_rd;
    eff_busy  = busy_q & ~wb_onehot;
    wb_clears = wb_valid & busy_q[wb_rd];
  end

  // Read-after-write hazard over all queried source operands.
  always_comb begin
    raw_stall = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (use_rs[i] && (rs_id[i] != 5'd0) && eff_busy[rs_id[i]]) raw_stall = 1'b1;
    end
  end

  // Capacity stall unless a writeback frees a slot in the same cycle.
  assign full_stall = issue_valid & issue_long & full & ~wb_clears;

`ifdef RV32_SB_WAW_CHECK_EN
  // Write-after-write: hold an issue whose destination is still pending.
  assign waw_stall = issue_valid & (issue_rd != 5'd0) & eff_busy[issue_rd];
`else
  // Re-issue to a busy destination is allowed; it simply keeps the bit set.
  assign waw_stall = 1'b0;
`endif

  assign stall  = ~flush & (raw_stall | full_stall | waw_stall);
  assign accept = issue_valid & issue_long & ~stall & (issue_rd != 5'd0);

  // Next busy vector: clear on writeback, then set on accept so set wins.
  always_comb begin
    busy_next = busy_q;
    if (wb_valid) busy_next[wb_rd] = 1'b0;
    if (accept) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Outstanding count is the population of the next busy vector, so it can
  // never drift from busy_mask; admission control keeps it <= MAX_OUTSTANDING.
  always_comb begin
    cnt_next = '0;
    for (int r = 1; r < 32; r++) cnt_next = cnt_next + 5'(busy_next[r]);
  end

  // State register: reset and flush discard all pending writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_next;
      cnt_q  <= cnt_next;
    end
  end

endmodule
